// File: rtl/nfc_data_out_sequencer_if.sv
// Bundled control, status and capture-path signals of the NV-DDR data-out sequencer.
// NFC_DATAOUT_LATENCY_EN adds the oLatency status bus.
interface nfc_data_out_sequencer_if;
    logic        iStart;
    logic [15:0] iBeatCount;
    logic        iAbort;
    logic        oReady;
    logic        oDone;
    logic        oError;
    logic [1:0]  oErrorCode;
    logic        iPI_DelayReady;
    logic        oPI_BufferReset;
    logic        oPI_Buff_WE;
    logic        oRE_n;
    logic        iPI_Buff_Valid;
    logic        iPI_Buff_Ready;
    logic        iPI_Buff_Last;
`ifdef NFC_DATAOUT_LATENCY_EN
    logic [15:0] oLatency;
`endif

    modport master (
        output iStart, iBeatCount, iAbort, iPI_DelayReady,
               iPI_Buff_Valid, iPI_Buff_Ready, iPI_Buff_Last,
`ifdef NFC_DATAOUT_LATENCY_EN
        input  oLatency,
`endif
        input  oReady, oDone, oError, oErrorCode,
               oPI_BufferReset, oPI_Buff_WE, oRE_n
    );

    modport slave (
        input  iStart, iBeatCount, iAbort, iPI_DelayReady,
               iPI_Buff_Valid, iPI_Buff_Ready, iPI_Buff_Last,
`ifdef NFC_DATAOUT_LATENCY_EN
        output oLatency,
`endif
        output oReady, oDone, oError, oErrorCode,
               oPI_BufferReset, oPI_Buff_WE, oRE_n
    );
endinterface

// File: rtl/nfc_data_out_sequencer.sv
// Sequences one NV-DDR data-out burst: buffer reset, RE_n preamble/toggle/postamble, beat drain.
// Optional NFC_DATAOUT_LATENCY_EN reports start-to-completion latency on oLatency.
module nfc_data_out_sequencer #(
    parameter int unsigned BufferResetCycles = 4,
    parameter int unsigned PreambleCycles    = 2,
    parameter int unsigned PostambleCycles   = 2,
    parameter int unsigned DrainTimeout      = 256
) (
    input  logic                           iSystemClock,
    input  logic                           iModuleReset_n,
    nfc_data_out_sequencer_if.slave        bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAITDLY, S_BRST, S_PRE, S_TOGGLE, S_POST,
        S_DRAIN, S_DONE, S_ERR, S_ABORT, S_ABRST
    } state_t;

    localparam logic [16:0] BRST_LAST  = 17'(BufferResetCycles - 1);
    localparam logic [16:0] PRE_LAST   = 17'(PreambleCycles - 1);
    localparam logic [16:0] POST_LAST  = 17'(PostambleCycles - 1);
    localparam logic [16:0] DRAIN_LAST = 17'(DrainTimeout - 1);

    state_t      r_state, w_next;
    logic [15:0] r_n;
    logic [15:0] r_beats;
    logic [16:0] r_cnt;
    logic        r_last_seen;
    logic [1:0]  r_err_code, w_err_code;

    logic        w_beat, w_last_beat, w_last_any, w_counting, w_burst, w_tog_last;
    logic [15:0] w_beats_next;

    assign w_beat       = bus.iPI_Buff_Valid & bus.iPI_Buff_Ready;
    assign w_last_beat  = w_beat & bus.iPI_Buff_Last;
    assign w_last_any   = r_last_seen | w_last_beat;
    assign w_beats_next = (w_beat && (r_beats != '1)) ? r_beats + 16'd1 : r_beats;
    assign w_counting   = (r_state == S_BRST) || (r_state == S_PRE) || (r_state == S_TOGGLE)
                       || (r_state == S_POST) || (r_state == S_DRAIN);
    assign w_burst      = w_counting || (r_state == S_WAITDLY);
    assign w_tog_last   = (r_cnt == ({r_n, 1'b0} - 17'd1));

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            r_state    <= S_IDLE;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_err_code <= w_err_code;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_code = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (bus.iStart) begin
                    w_next     = (bus.iBeatCount == 16'd0) ? S_DONE : S_WAITDLY;
                    w_err_code = 2'b00;
                end
            end
            S_WAITDLY: if (bus.iPI_DelayReady) w_next = S_BRST;
            S_BRST:    if (r_cnt == BRST_LAST) w_next = S_PRE;
            S_PRE:     if (r_cnt == PRE_LAST)  w_next = S_TOGGLE;
            S_TOGGLE:  if (w_tog_last)         w_next = S_POST;
            S_POST:    if (r_cnt == POST_LAST) w_next = S_DRAIN;
            S_DRAIN: begin
                // A Last recorded before DRAIN is judged here against the running beat total.
                if (w_last_any && (w_beats_next == r_n)) begin
                    w_next = S_DONE;
                end else if (w_last_any && (w_beats_next < r_n)) begin
                    w_next     = S_ERR;
                    w_err_code = 2'b10;
                end else if (w_beats_next > r_n) begin
                    w_next     = S_ERR;
                    w_err_code = 2'b11;
                end else if (r_cnt == DRAIN_LAST) begin
                    w_next     = S_ERR;
                    w_err_code = 2'b01;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            S_ABORT: w_next = S_ABRST;
            S_ABRST: begin
                if (r_cnt == BRST_LAST) begin
                    w_next     = S_ERR;
                    w_err_code = 2'b00;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Abort only interrupts an active burst; the cleanup and pulse states run to completion.
        if (w_burst && bus.iAbort) begin
            w_next     = S_ABORT;
            w_err_code = r_err_code;
        end
    end

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            r_n         <= '0;
            r_beats     <= '0;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 17'd1;
            if ((r_state == S_IDLE) && bus.iStart) begin
                r_n         <= bus.iBeatCount;
                r_beats     <= '0;
                r_last_seen <= 1'b0;
            end else if (w_counting) begin
                r_beats <= w_beats_next;
                if (w_last_beat) r_last_seen <= 1'b1;
            end
        end
    end

    assign bus.oReady          = (r_state == S_IDLE);
    assign bus.oDone           = (r_state == S_DONE);
    assign bus.oError          = (r_state == S_ERR);
    assign bus.oErrorCode      = r_err_code;
    assign bus.oPI_BufferReset = (r_state == S_BRST) || (r_state == S_ABRST);
    assign bus.oPI_Buff_WE     = (r_state == S_PRE) || (r_state == S_TOGGLE) || (r_state == S_POST);
    assign bus.oRE_n           = !((r_state == S_PRE) || ((r_state == S_TOGGLE) && r_cnt[0]));

`ifdef NFC_DATAOUT_LATENCY_EN
    logic [15:0] r_lat_cnt, r_latency;
    logic [15:0] w_lat_inc;

    assign w_lat_inc = (r_lat_cnt == '1) ? '1 : r_lat_cnt + 16'd1;

    // The acceptance cycle counts as one, so the pulse cycle reports r_lat_cnt + 1.
    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            r_lat_cnt <= '0;
            r_latency <= '0;
        end else begin
            if ((r_state == S_IDLE) && bus.iStart) r_lat_cnt <= 16'd1;
            else if (r_state != S_IDLE)            r_lat_cnt <= w_lat_inc;
            if ((r_state == S_DONE) || (r_state == S_ERR)) r_latency <= w_lat_inc;
        end
    end

    assign bus.oLatency = r_latency;
`endif

endmodule

// File: doc/nfc_data_out_sequencer.md
Name: nfc_data_out_sequencer

Overview:
- Sequences one NV-DDR data-out (read) burst through the physical input capture path.
- Waits for delay-line ready, then pulses the capture buffer reset and drives RE_n (preamble, toggle, postamble).
- Gates the capture buffer write enable and snoops the 16-bit capture output stream to count beats.
- Reports done or error to the NAND command engine; sits between that engine and the physical input/output blocks.

Parameters:
- BufferResetCycles, 4: cycles the capture buffer reset is held high (minimum 1).
- PreambleCycles, 2: cycles RE_n is held low before toggling (tRPRE).
- PostambleCycles, 2: cycles RE_n is held high after toggling while WE stays asserted (tRPST).
- DrainTimeout, 256: maximum DRAIN cycles before a timeout error.

Ports:
- iSystemClock  in  1  single clock for all logic.
- iModuleReset_n  in  1  asynchronous active-low reset.
- iStart  in  1  start a burst; sampled in IDLE only.
- iBeatCount  in  16  burst length in 16-bit beats; one beat = one RE_n period = two bytes.
- iAbort  in  1  abort the current burst.
- oReady  out  1  high in IDLE.
- oDone  out  1  one-cycle pulse on successful completion.
- oError  out  1  one-cycle pulse on failure.
- oErrorCode  out  2  01 timeout, 10 short (Last before N beats), 11 overflow, 00 abort; held until next iStart.
- iPI_DelayReady  in  1  delay-line calibrated.
- oPI_BufferReset  out  1  capture buffer reset.
- oPI_Buff_WE  out  1  capture buffer write-enable window.
- oRE_n  out  1  RE_n level to the output pad path.
- iPI_Buff_Valid, iPI_Buff_Ready, iPI_Buff_Last  in  1 each  stream snoop.

Behaviour:
- Reset values: oReady=1, oDone=0, oError=0, oErrorCode=00, oPI_BufferReset=0, oPI_Buff_WE=0, oRE_n=1. State=IDLE, counters cleared.
- Beat counter: increments on each cycle with iPI_Buff_Valid & iPI_Buff_Ready, from BRST entry until DONE. 16 bits, saturates at FFFF.
- IDLE: iStart=1 latches N=iBeatCount and clears oErrorCode.
  - N=0: oDone pulses next cycle; no physical activity.
  - Otherwise go to WAITDLY. iStart outside IDLE is ignored.
- WAITDLY: stay until iPI_DelayReady=1, then go to BRST. No timeout.
- BRST: oPI_BufferReset=1 for exactly BufferResetCycles cycles, then PRE.
- PRE: oRE_n=0 and oPI_Buff_WE=1 for PreambleCycles cycles, then TOGGLE.
- TOGGLE: oRE_n alternates 1,0,1,0... starting high on the first cycle, for exactly 2N cycles. Then POST.
- POST: oRE_n=1 and oPI_Buff_WE=1 for PostambleCycles cycles, then DRAIN.
- DRAIN: oPI_Buff_WE=0, oRE_n=1. Exit checks, in priority order:
  - count==N at a Last beat: DONE.
  - Last with count<N: ERR code 10.
  - a beat with count>N: ERR code 11.
  - DrainTimeout cycles with no exit: ERR code 01.
- Beats arriving before DRAIN are counted. A Last seen before DRAIN is recorded and evaluated on DRAIN entry.
- DONE: oDone pulses one cycle, then IDLE. ERR: oError pulses one cycle, oErrorCode set, then IDLE.
- iAbort (any non-IDLE state, highest priority): next cycle oPI_Buff_WE=0 and oRE_n=1. Then oPI_BufferReset=1 for BufferResetCycles cycles, oError pulses with code 00, then IDLE. iAbort in IDLE does nothing.
- iStart and iAbort together in IDLE: iAbort ignored, start accepted.
- Asynchronous reset mid-burst: all outputs return to reset values immediately.

Optional Feature:
- Macro: NFC_DATAOUT_LATENCY_EN.
- When defined: adds output oLatency[15:0], the cycles from iStart acceptance to the oDone/oError pulse inclusive. Saturates at FFFF, updated on the pulse, reset to 0.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic burst: N=4, delay ready, stream returns 4 beats with Last on the 4th.
  - Required: BRST 4 cycles, RE_n low 2 cycles, 8 toggle cycles, WE high for 2+8+2 cycles, oDone pulse, oErrorCode=00.
- N=0: single oDone pulse one cycle after iStart; oPI_BufferReset, oPI_Buff_WE and oRE_n stay at reset values.
- Short burst: N=8, Last on beat 5 -> oError with code 10.
- Overflow: N=2, beats 1-3 without Last -> code 11 at beat 3.
- Timeout: N=4, no Valid ever -> oError code 01 exactly 256 DRAIN cycles after POST exit.
- Abort and reset:
  - iAbort in TOGGLE -> next cycle WE=0, RE_n=1, then BufferReset 4 cycles, code 00, oReady=1.
  - iModuleReset_n low in PRE -> outputs at reset values immediately.
  - iPI_DelayReady held low 100 cycles -> BRST starts only after it rises.
